// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_pkg;

    // Bus FSM: IDLE issues new accesses, WAIT holds the bus until ack.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // funct3 encodings for loads/stores (bit 2 = unsigned load).
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Default wait-state limit used when MEM_TIMEOUT_EN is defined.
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Byte enables for an access of funct3[1:0] size at byte offset off.
    function automatic logic [3:0] size_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: selects the addressed byte/half of a bus
// word and sign- or zero-extends it according to funct3.
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: drives a req/ack data bus with variable latency,
// aligns stores and loads, flags misaligned/illegal accesses, stalls the
// pipe while an access is outstanding and registers the MEM/WB boundary.
// Optional macro MEM_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES wait
// cycles and flag it as an error.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            RegWrite_in,
    input  logic            MemWrite_in,
    input  logic            MemRead_in,
    input  logic [1:0]      MemtoReg_in,
    input  logic [2:0]      funct3_in,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] result_in,
    input  logic [XLEN-1:0] writeData_in,
    input  logic [XLEN-1:0] NextAddr_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            mem_stall,
    output logic            RegWrite_wb,
    output logic [1:0]      MemtoReg_wb,
    output logic [4:0]      rd_wb,
    output logic [XLEN-1:0] result_wb,
    output logic [XLEN-1:0] load_data_wb,
    output logic [XLEN-1:0] NextAddr_wb,
    output logic            mem_err_wb
);

    if (XLEN != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_param_check
        $error("mem_access_stage: XLEN must be 32 and TIMEOUT_CYCLES must be 1..256");
    end

    mem_state_e state_q, state_d;

    logic            access;
    logic            misaligned;
    logic            reserved;
    logic            illegal;
    logic            issue;
    logic            enter_wait;
    logic            timeout_hit;
    logic [3:0]      new_be;
    logic [XLEN-1:0] new_wdata;

    logic [XLEN-1:0] cap_addr;
    logic [3:0]      cap_be;
    logic [XLEN-1:0] cap_wdata;
    logic            cap_we;
    logic [2:0]      cap_f3;

    logic [2:0]      la_f3;
    logic [1:0]      la_off;
    logic [XLEN-1:0] aligned_data;
    logic            load_done;
    logic [XLEN-1:0] load_next;
    logic            err_next;

    // Access decode: legality and store lane formatting from EX/MEM inputs.
    always_comb begin
        access     = MemRead_in | MemWrite_in;
        misaligned = ((funct3_in[1:0] == 2'b01) && result_in[0]) ||
                     ((funct3_in[1:0] == 2'b10) && (result_in[1:0] != 2'b00));
        reserved   = (MemRead_in && (funct3_in == 3'b011 || funct3_in == 3'b110 ||
                                     funct3_in == 3'b111)) ||
                     (MemWrite_in && !(funct3_in == F3_B || funct3_in == F3_H ||
                                       funct3_in == F3_W));
        illegal    = access && (misaligned || reserved);
        issue      = access && !illegal;
        new_be     = size_be(funct3_in[1:0], result_in[1:0]);
        case (funct3_in[1:0])
            2'b00:   new_wdata = {4{writeData_in[7:0]}};
            2'b01:   new_wdata = {2{writeData_in[15:0]}};
            default: new_wdata = writeData_in;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Wait-state counter: zero whenever IDLE, so it starts at 0 on entering WAIT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wait_cnt <= '0;
        else if (state_q == IDLE)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 8'd1;
    end

    assign timeout_hit = (state_q == WAIT) && !dmem_ack &&
                         (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state, bus drive and stall. Reset gates req/stall combinationally
    // so the bus request drops the moment rstn falls.
    always_comb begin
        state_d    = state_q;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_wdata = '0;
        mem_stall  = 1'b0;
        enter_wait = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    dmem_req   = 1'b1;
                    dmem_we    = MemWrite_in;
                    dmem_addr  = {result_in[XLEN-1:2], 2'b00};
                    dmem_be    = new_be;
                    dmem_wdata = new_wdata;
                    if (!dmem_ack) begin
                        state_d    = WAIT;
                        mem_stall  = 1'b1;
                        enter_wait = 1'b1;
                    end
                end
            end
            WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = cap_we;
                dmem_addr  = {cap_addr[XLEN-1:2], 2'b00};
                dmem_be    = cap_be;
                dmem_wdata = cap_wdata;
                if (dmem_ack || timeout_hit)
                    state_d = IDLE;
                else
                    mem_stall = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (!rstn) begin
            dmem_req   = 1'b0;
            mem_stall  = 1'b0;
            enter_wait = 1'b0;
        end
    end

    // Capture the bus transaction when an access has to wait.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_addr  <= '0;
            cap_be    <= '0;
            cap_wdata <= '0;
            cap_we    <= 1'b0;
            cap_f3    <= '0;
        end else if (enter_wait) begin
            cap_addr  <= result_in;
            cap_be    <= new_be;
            cap_wdata <= new_wdata;
            cap_we    <= MemWrite_in;
            cap_f3    <= funct3_in;
        end
    end

    // Load alignment uses the captured access while waiting.
    always_comb begin
        la_f3  = (state_q == WAIT) ? cap_f3 : funct3_in;
        la_off = (state_q == WAIT) ? cap_addr[1:0] : result_in[1:0];
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3    (la_f3),
        .addr_lo   (la_off),
        .rdata     (dmem_rdata),
        .load_data (aligned_data)
    );

    // Writeback values presented to MEM/WB in a non-stalled cycle.
    always_comb begin
        if (state_q == WAIT) begin
            load_done = !cap_we && dmem_ack;
            err_next  = timeout_hit;
        end else begin
            load_done = MemRead_in && !MemWrite_in && !illegal;
            err_next  = illegal;
        end
        load_next = load_done ? aligned_data : '0;
    end

    // MEM/WB register: advances when not stalled, bubbles while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            RegWrite_wb  <= 1'b0;
            MemtoReg_wb  <= 2'b01;
            rd_wb        <= '0;
            result_wb    <= '0;
            load_data_wb <= '0;
            NextAddr_wb  <= '0;
            mem_err_wb   <= 1'b0;
        end else if (mem_stall) begin
            RegWrite_wb <= 1'b0;
            mem_err_wb  <= 1'b0;
        end else begin
            RegWrite_wb  <= RegWrite_in && !err_next;
            MemtoReg_wb  <= MemtoReg_in;
            rd_wb        <= rd_in;
            result_wb    <= result_in;
            load_data_wb <= load_next;
            NextAddr_wb  <= NextAddr_in;
            mem_err_wb   <= err_next;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: zero-wait vector table plus
// directed wait-state, reset-in-WAIT and (MEM_TIMEOUT_EN) timeout sequences.
module tb_mem_access_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        RegWrite_in, MemWrite_in, MemRead_in;
    logic [1:0]  MemtoReg_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic [31:0] result_in, writeData_in, NextAddr_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        RegWrite_wb;
    logic [1:0]  MemtoReg_wb;
    logic [4:0]  rd_wb;
    logic [31:0] result_wb, load_data_wb, NextAddr_wb;
    logic        mem_err_wb;

    int n_total = 0;
    int n_pass  = 0;

    mem_access_stage #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn),
        .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .MemtoReg_in(MemtoReg_in), .funct3_in(funct3_in), .rd_in(rd_in),
        .result_in(result_in), .writeData_in(writeData_in), .NextAddr_in(NextAddr_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall), .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
        .rd_wb(rd_wb), .result_wb(result_wb), .load_data_wb(load_data_wb),
        .NextAddr_wb(NextAddr_wb), .mem_err_wb(mem_err_wb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        rd_e, wr_e, rw;
        logic [1:0]  m2r;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdata;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_rw;
        logic [31:0] e_ld;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic rd_e, wr_e, rw,
                                input logic [1:0] m2r, input logic [2:0] f3,
                                input logic [31:0] addr, wd, rdata, input logic ack,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic [3:0] e_be, input logic [31:0] e_wdata,
                                input logic e_rw, input logic [31:0] e_ld, input logic e_err);
        vec_t v;
        v.name = name; v.rd_e = rd_e; v.wr_e = wr_e; v.rw = rw; v.m2r = m2r; v.f3 = f3;
        v.addr = addr; v.wd = wd; v.rdata = rdata; v.ack = ack;
        v.e_req = e_req; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_rw = e_rw; v.e_ld = e_ld; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic rd_e, wr_e, rw, input logic [1:0] m2r,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] addr, wd, na, rdata, input logic ack);
        MemRead_in = rd_e; MemWrite_in = wr_e; RegWrite_in = rw; MemtoReg_in = m2r;
        funct3_in = f3; rd_in = rd; result_in = addr; writeData_in = wd;
        NextAddr_in = na; dmem_rdata = rdata; dmem_ack = ack;
    endtask

    task automatic drive_nop();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Load that completes after nwait stall cycles; hold = result_wb during bubbles.
    task automatic wait_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input int nwait, input logic [3:0] e_be,
                             input logic [31:0] e_ld, input logic [31:0] hold);
        for (int k = 0; k <= nwait; k++) begin
            @(negedge clk);
            if (k == 0) drive(1'b1, 1'b0, 1'b1, 2'b01, f3, 5'd9, addr, 32'h0, 32'h4444, rdata, 1'b0);
            dmem_ack = (k == nwait);
            #1;
            chk({name, ".req"}, 32'(dmem_req), 32'd1);
            chk({name, ".stall"}, 32'(mem_stall), 32'(k < nwait));
            chk({name, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
            chk({name, ".be"}, 32'(dmem_be), 32'(e_be));
            @(posedge clk); #1;
            if (k < nwait) begin
                chk({name, ".bubble_rw"}, 32'(RegWrite_wb), 32'd0);
                chk({name, ".bubble_err"}, 32'(mem_err_wb), 32'd0);
                chk({name, ".hold_result"}, result_wb, hold);
            end else begin
                chk({name, ".rw_wb"}, 32'(RegWrite_wb), 32'd1);
                chk({name, ".load_wb"}, load_data_wb, e_ld);
                chk({name, ".result_wb"}, result_wb, addr);
                chk({name, ".err_wb"}, 32'(mem_err_wb), 32'd0);
            end
        end
        @(negedge clk);
        drive_nop();
    endtask

    initial begin
        vecs.push_back(mk("SW",      0,1,0,2'b00,3'b010,32'h104,32'hDEADBEEF,32'h0,1, 1,32'h104,4'hF,32'hDEADBEEF,0,32'h0,0));
        vecs.push_back(mk("SH",      0,1,0,2'b00,3'b001,32'h202,32'h00001234,32'h0,1, 1,32'h200,4'hC,32'h12341234,0,32'h0,0));
        vecs.push_back(mk("SB",      0,1,0,2'b00,3'b000,32'h301,32'h000000A5,32'h0,1, 1,32'h300,4'h2,32'hA5A5A5A5,0,32'h0,0));
        vecs.push_back(mk("LW",      1,0,1,2'b01,3'b010,32'h100,32'h0,32'hCAFEF00D,1, 1,32'h100,4'hF,32'h0,1,32'hCAFEF00D,0));
        vecs.push_back(mk("LH",      1,0,1,2'b01,3'b001,32'h102,32'h0,32'h80011234,1, 1,32'h100,4'hC,32'h0,1,32'hFFFF8001,0));
        vecs.push_back(mk("LHU",     1,0,1,2'b01,3'b101,32'h102,32'h0,32'h80011234,1, 1,32'h100,4'hC,32'h0,1,32'h00008001,0));
        vecs.push_back(mk("LB",      1,0,1,2'b01,3'b000,32'h101,32'h0,32'h00007F00,1, 1,32'h100,4'h2,32'h0,1,32'h0000007F,0));
        vecs.push_back(mk("LBU",     1,0,1,2'b01,3'b100,32'h102,32'h0,32'h00AB0000,1, 1,32'h100,4'h4,32'h0,1,32'h000000AB,0));
        vecs.push_back(mk("LW_mis",  1,0,1,2'b01,3'b010,32'h101,32'h0,32'h0,0, 0,32'h0,4'h0,32'h0,0,32'h0,1));
        vecs.push_back(mk("LH_mis",  1,0,1,2'b01,3'b001,32'h103,32'h0,32'h0,0, 0,32'h0,4'h0,32'h0,0,32'h0,1));
        vecs.push_back(mk("LD_rsv",  1,0,1,2'b01,3'b011,32'h100,32'h0,32'h0,0, 0,32'h0,4'h0,32'h0,0,32'h0,1));
        vecs.push_back(mk("ST_rsv",  0,1,0,2'b00,3'b100,32'h100,32'h0,32'h0,0, 0,32'h0,4'h0,32'h0,0,32'h0,1));
        vecs.push_back(mk("ALU",     0,0,1,2'b00,3'b000,32'h55,32'h0,32'h0,1, 0,32'h0,4'h0,32'h0,1,32'h0,0));
        vecs.push_back(mk("JAL",     0,0,1,2'b10,3'b000,32'h200,32'h0,32'h0,0, 0,32'h0,4'h0,32'h0,1,32'h0,0));

        // Reset state
        rstn = 1'b0;
        drive_nop();
        #12;
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.stall", 32'(mem_stall), 32'd0);
        chk("rst.rw_wb", 32'(RegWrite_wb), 32'd0);
        chk("rst.m2r_wb", 32'(MemtoReg_wb), 32'd1);
        chk("rst.result_wb", result_wb, 32'h0);
        chk("rst.err_wb", 32'(mem_err_wb), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Zero-wait vector table
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rd_e, vecs[i].wr_e, vecs[i].rw, vecs[i].m2r, vecs[i].f3, 5'(i + 1),
                  vecs[i].addr, vecs[i].wd, 32'h1000 + 32'(i) * 4, vecs[i].rdata, vecs[i].ack);
            #1;
            chk({vecs[i].name, ".req"}, 32'(dmem_req), 32'(vecs[i].e_req));
            chk({vecs[i].name, ".stall"}, 32'(mem_stall), 32'd0);
            if (vecs[i].e_req) begin
                chk({vecs[i].name, ".we"}, 32'(dmem_we), 32'(vecs[i].wr_e));
                chk({vecs[i].name, ".addr"}, dmem_addr, vecs[i].e_addr);
                chk({vecs[i].name, ".be"}, 32'(dmem_be), 32'(vecs[i].e_be));
                if (vecs[i].wr_e) chk({vecs[i].name, ".wdata"}, dmem_wdata, vecs[i].e_wdata);
            end
            @(posedge clk); #1;
            chk({vecs[i].name, ".rw_wb"}, 32'(RegWrite_wb), 32'(vecs[i].e_rw));
            chk({vecs[i].name, ".m2r_wb"}, 32'(MemtoReg_wb), 32'(vecs[i].m2r));
            chk({vecs[i].name, ".rd_wb"}, 32'(rd_wb), 32'(i + 1));
            chk({vecs[i].name, ".result_wb"}, result_wb, vecs[i].addr);
            chk({vecs[i].name, ".load_wb"}, load_data_wb, vecs[i].e_ld);
            chk({vecs[i].name, ".next_wb"}, NextAddr_wb, 32'h1000 + 32'(i) * 4);
            chk({vecs[i].name, ".err_wb"}, 32'(mem_err_wb), 32'(vecs[i].e_err));
        end

        // Wait-state loads: 3 stall cycles then ack
        wait_load("LB_wait", 3'b000, 32'h103, 32'h80FF0000, 3, 4'h8, 32'hFFFFFF80, 32'h200);
        wait_load("LBU_wait", 3'b100, 32'h103, 32'h80FF0000, 3, 4'h8, 32'h00000080, 32'h0);

        // Reset while WAIT
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 5'd3, 32'h100, 32'h0, 32'h1234, 32'h0, 1'b0);
        #1 chk("rstw.stall_issue", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        chk("rstw.req_wait", 32'(dmem_req), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rstw.req", 32'(dmem_req), 32'd0);
        chk("rstw.stall", 32'(mem_stall), 32'd0);
        chk("rstw.m2r_wb", 32'(MemtoReg_wb), 32'd1);
        chk("rstw.next_wb", NextAddr_wb, 32'h0);
        chk("rstw.rd_wb", 32'(rd_wb), 32'd0);
        @(negedge clk);
        drive_nop();
        dmem_ack = 1'b1;
        rstn = 1'b1;
        #1;
        chk("rstw.late_ack_req", 32'(dmem_req), 32'd0);
        chk("rstw.late_ack_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("rstw.late_ack_rw", 32'(RegWrite_wb), 32'd0);
        chk("rstw.late_ack_ld", load_data_wb, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 5'd0, 32'h204, 32'h11223344, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rstw.idle_addr", dmem_addr, 32'h204);
        chk("rstw.idle_we", 32'(dmem_we), 32'd1);
        chk("rstw.idle_stall", 32'(mem_stall), 32'd1);
        @(negedge clk);
        dmem_ack = 1'b1;
        #1 chk("rstw.store_done", 32'(mem_stall), 32'd0);
        @(negedge clk);
        drive_nop();

`ifdef MEM_TIMEOUT_EN
        // Timeout: ack never arrives; abort after TO wait cycles
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 5'd4, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k <= TO; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("to.req", 32'(dmem_req), 32'd1);
            chk("to.stall", 32'(mem_stall), 32'(k < TO));
            @(posedge clk); #1;
        end
        chk("to.err_wb", 32'(mem_err_wb), 32'd1);
        chk("to.rw_wb", 32'(RegWrite_wb), 32'd0);
        chk("to.ld_wb", load_data_wb, 32'h0);
        @(negedge clk);
        drive_nop();
        dmem_ack = 1'b1;
        #1;
        chk("to.after_req", 32'(dmem_req), 32'd0);
        chk("to.after_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("to.late_ack_err", 32'(mem_err_wb), 32'd0);
        chk("to.late_ack_rw", 32'(RegWrite_wb), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
